// File: rtl/dmem_ctrl.sv
// Data-memory access controller: M-stage load/store to a two-phase (addr/data) bus.
// Optional alignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int ALIGN_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic [3:0]  sig_write,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        stall_ext,
  output logic [31:0] readdataM,
  output logic        stall_memM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        adelM,
  output logic        adesM
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic misaligned;
  logic err;
  logic issue;
  logic st_idle, st_req, st_wait;

  always_comb begin
    misaligned = 1'b0;
    case (sizeM)
      2'd1:    misaligned = aluoutM[0];
      2'd2:    misaligned = |aluoutM[ALIGN_W-1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err     = CHECK_EN & misaligned;
  assign issue   = memenM & ~flushM & ~err;
  assign st_idle = (state_q == S_IDLE);
  assign st_req  = (state_q == S_REQ);
  assign st_wait = (state_q == S_WAIT);

  // Request/stall are gated by rst so an M instruction held during reset cannot leak a request.
  assign data_req   = rst & ((st_idle & issue) | st_req);
  assign stall_memM = rst & ((st_idle & issue) | st_req | (st_wait & ~data_data_ok));
  assign readdataM  = st_wait ? data_rdata : rdata_q;

  assign data_wr    = memwriteM;
  assign data_size  = sizeM;
  assign data_addr  = aluoutM;
  assign data_wdata = writedataM;
  assign data_wstrb = memwriteM ? sig_write : 4'b0000;

  assign adelM = rst & err & memenM & ~memwriteM;
  assign adesM = rst & err & memenM & memwriteM;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = stall_ext ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!stall_ext) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, hand sequences (HOLD, reset in WAIT),
// and randomized traffic against a transaction-level reference model.
module tb_dmem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memenM = 1'b0, memwriteM = 1'b0, flushM = 1'b0, stall_ext = 1'b0;
  logic [1:0]  sizeM = '0;
  logic [3:0]  sig_write = '0;
  logic [31:0] aluoutM = '0, writedataM = '0, data_rdata = '0;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] readdataM, data_addr, data_wdata;
  logic        stall_memM, data_req, data_wr, adelM, adesM;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  always #5 clk = ~clk;

  dmem_ctrl #(.ALIGN_W(2)) dut (
    .clk(clk), .rst(rst),
    .memenM(memenM), .memwriteM(memwriteM), .sizeM(sizeM), .sig_write(sig_write),
    .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM), .stall_ext(stall_ext),
    .readdataM(readdataM), .stall_memM(stall_memM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .adelM(adelM), .adesM(adesM)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        memen, memwr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr, wdata;
    logic        flush, sext, aok, dok;
    logic [31:0] rdata;
    logic        crd;
    logic        ereq, estall;
    logic [31:0] erd;
    logic [3:0]  ewstrb;
    logic        eadel, eades;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    memenM = v.memen; memwriteM = v.memwr; sizeM = v.size; sig_write = v.strb;
    aluoutM = v.addr; writedataM = v.wdata; flushM = v.flush; stall_ext = v.sext;
    data_addr_ok = v.aok; data_data_ok = v.dok; data_rdata = v.rdata;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".req"},   data_req,   v.ereq);
    chk({tag, ".stall"}, stall_memM, v.estall);
    if (v.crd) chk({tag, ".rdata"}, readdataM, v.erd);
    chk({tag, ".wstrb"}, data_wstrb, v.ewstrb);
    chk({tag, ".adel"},  adelM,      v.eadel);
    chk({tag, ".ades"},  adesM,      v.eades);
    chk({tag, ".addr"},  data_addr,  v.addr);
    chk({tag, ".wdata"}, data_wdata, v.wdata);
    chk({tag, ".wr"},    data_wr,    v.memwr);
    chk({tag, ".size"},  data_size,  v.size);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{memen:1'b0, memwr:1'b0, size:2'd2, strb:4'h0, addr:32'h0, wdata:32'h0,
          flush:1'b0, sext:1'b0, aok:1'b0, dok:1'b0, rdata:32'h0, crd:1'b1,
          ereq:1'b0, estall:1'b0, erd:32'h0, ewstrb:4'h0, eadel:1'b0, eades:1'b0};
    return v;
  endfunction

  task automatic do_reset();
    vec_t z;
    z = blank();
    @(negedge clk);
    rst = 1'b0;
    drive(z);
    #1;
    chk("rst.req",   data_req,   1'b0);
    chk("rst.stall", stall_memM, 1'b0);
    chk("rst.rdata", readdataM,  32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  // Transaction-level reference: what the bus still owes and whether a result is parked.
  bit          m_addr_owed, m_data_owed, m_parked;
  logic [31:0] m_rdq;

  initial begin
    vec_t v;

    // memen memwr size strb addr wdata flush sext aok dok rdata | crd req stall rd wstrb adel ades
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h100,32'h0,0,0,1,0,32'h0,             1,1,1,32'h0,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h100,32'h0,0,0,0,1,32'hDEADBEEF,      1,0,0,32'hDEADBEEF,4'h0,0,0});
    vecs.push_back(vec_t'{0,0,2,4'h0,32'h100,32'h0,0,0,0,0,32'h0,             1,0,0,32'hDEADBEEF,4'h0,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,0,0,32'h0,      1,1,1,32'hDEADBEEF,4'h8,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,0,0,32'h0,      1,1,1,32'hDEADBEEF,4'h8,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,0,0,32'h0,      1,1,1,32'hDEADBEEF,4'h8,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,1,0,32'h0,      1,1,1,32'hDEADBEEF,4'h8,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,0,0,32'h11111111,1,0,1,32'h11111111,4'h8,0,0});
    vecs.push_back(vec_t'{1,1,0,4'h8,32'h203,32'hAB000000,0,0,0,1,32'h22222222,1,0,0,32'h22222222,4'h8,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h108,32'h0,1,0,1,0,32'h0,             1,0,0,32'h22222222,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h104,32'h0,0,0,0,0,32'h0,             1,1,1,32'h22222222,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h104,32'h0,1,0,0,0,32'h0,             1,1,1,32'h22222222,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h104,32'h0,1,0,1,0,32'h0,             1,1,1,32'h22222222,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h104,32'h0,1,0,0,1,32'h33333333,      1,0,0,32'h33333333,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h104,32'h0,1,0,1,0,32'h0,             1,0,0,32'h33333333,4'h0,0,0});
    vecs.push_back(vec_t'{1,0,2,4'h0,32'h102,32'h0,0,0,1,0,32'h0,
                          1,!CHK,!CHK,32'h33333333,4'h0,CHK,0});
    vecs.push_back(vec_t'{0,0,2,4'h0,32'h102,32'h0,0,0,0,1,32'h44444444,
                          1,0,0,(CHK ? 32'h33333333 : 32'h44444444),4'h0,0,0});
    vecs.push_back(vec_t'{1,1,1,4'h8,32'h103,32'hAB000000,0,0,0,0,32'h0,
                          1,!CHK,!CHK,(CHK ? 32'h33333333 : 32'h44444444),4'h8,0,CHK});
    vecs.push_back(vec_t'{0,0,2,4'h0,32'h103,32'h0,0,0,1,0,32'h0,
                          1,!CHK,!CHK,(CHK ? 32'h33333333 : 32'h44444444),4'h0,0,0});
    vecs.push_back(vec_t'{0,0,2,4'h0,32'h103,32'h0,0,0,0,1,32'h55555555,
                          1,0,0,(CHK ? 32'h33333333 : 32'h55555555),4'h0,0,0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while waiting for data.
    v = blank(); v.memen = 1; v.addr = 32'h300; v.aok = 1; v.crd = 0; v.ereq = 1; v.estall = 1;
    apply(v, "rw.issue");
    v = blank(); v.memen = 1; v.addr = 32'h300; v.rdata = 32'h77777777;
    drive(v);
    #1;
    chk("rw.wait_rdata", readdataM,  32'h77777777);
    chk("rw.wait_stall", stall_memM, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rw.req",   data_req,   1'b0);
    chk("rw.stall", stall_memM, 1'b0);
    chk("rw.rdata", readdataM,  32'h0);
    chk("rw.adel",  adelM,      1'b0);
    chk("rw.ades",  adesM,      1'b0);
    @(posedge clk);
    #1;
    chk("rw.held_req", data_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    v = blank();
    drive(v);
    @(posedge clk);
    #1;
    apply(v, "rw.idle");
    v = blank(); v.memen = 1; v.addr = 32'h304; v.aok = 1; v.ereq = 1; v.estall = 1;
    apply(v, "rw.reissue");
    v = blank(); v.memen = 1; v.addr = 32'h304; v.dok = 1; v.rdata = 32'h99; v.erd = 32'h99;
    apply(v, "rw.done");

    // Data returns while the pipeline is held: result parks, no re-issue.
    v = blank(); v.memen = 1; v.addr = 32'h200; v.aok = 1; v.ereq = 1; v.estall = 1; v.erd = 32'h99;
    apply(v, "hold.issue");
    v = blank(); v.memen = 1; v.addr = 32'h200; v.sext = 1; v.dok = 1; v.rdata = 32'h5555AAAA;
    v.erd = 32'h5555AAAA;
    apply(v, "hold.data");
    for (int i = 0; i < 3; i++) begin
      v = blank(); v.memen = 1; v.addr = 32'h200; v.sext = 1; v.aok = 1; v.dok = 1;
      v.rdata = 32'hBAD0BAD0; v.erd = 32'h5555AAAA;
      apply(v, $sformatf("hold.park%0d", i));
    end
    v = blank(); v.memen = 1; v.addr = 32'h200; v.aok = 1; v.erd = 32'h5555AAAA;
    apply(v, "hold.release");
    v = blank(); v.erd = 32'h5555AAAA;
    apply(v, "hold.idle");

    // Randomized traffic against the reference model.
    do_reset();
    m_addr_owed = 0; m_data_owed = 0; m_parked = 0; m_rdq = '0;
    for (int n = 0; n < 600; n++) begin
      bit err, issue, free;
      v = blank();
      v.memen = ($urandom_range(0, 9) < 7);
      v.memwr = $urandom_range(0, 1);
      v.size  = 2'($urandom_range(0, 2));
      v.strb  = 4'($urandom);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.flush = ($urandom_range(0, 9) < 2);
      v.sext  = ($urandom_range(0, 9) < 3);
      v.aok   = $urandom_range(0, 1);
      v.dok   = $urandom_range(0, 1);
      v.rdata = $urandom;
      err   = CHK && ((v.size == 2'd1 && v.addr[0]) || (v.size == 2'd2 && v.addr[1:0] != 2'b00));
      issue = v.memen && !v.flush && !err;
      free  = !m_addr_owed && !m_data_owed && !m_parked;
      v.ereq   = (free && issue) || m_addr_owed;
      v.estall = (free && issue) || m_addr_owed || (m_data_owed && !v.dok);
      v.erd    = m_data_owed ? v.rdata : m_rdq;
      v.ewstrb = v.memwr ? v.strb : 4'h0;
      v.eadel  = err && v.memen && !v.memwr;
      v.eades  = err && v.memen && v.memwr;
      apply(v, $sformatf("rnd%0d", n));
      if (free && issue) begin
        if (v.aok) m_data_owed = 1;
        else       m_addr_owed = 1;
      end else if (m_addr_owed && v.aok) begin
        m_addr_owed = 0;
        m_data_owed = 1;
      end else if (m_data_owed && v.dok) begin
        m_data_owed = 0;
        m_rdq       = v.rdata;
        m_parked    = v.sext;
      end else if (m_parked && !v.sext) begin
        m_parked = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the datapath's memory stage and the external SRAM-like data bus. It turns the M-stage load/store request (address, byte strobes, write data) into a two-phase bus transaction (address handshake, then data handshake) and stalls the pipeline until the data phase completes. It returns load data to the M/W pipeline register, and it holds that data until the pipeline actually advances, so a request is never re-issued.

## Interface
- `ALIGN_W`, default 2: number of low address bits checked by the alignment option.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `memenM` in 1: M-stage instruction is a load or store.
- `memwriteM` in 1: 1 = store, 0 = load.
- `sizeM` in 2: access size: 0 = byte, 1 = half, 2 = word.
- `sig_write` in 4: store byte strobes, already lane-aligned.
- `aluoutM` in 32: byte address.
- `writedataM` in 32: lane-aligned store data.
- `flushM` in 1: M-stage instruction is cancelled.
- `stall_ext` in 1: pipeline held by another source (div, fetch).
- `readdataM` out 32: load data to the M/W register.
- `stall_memM` out 1: stall request to the hazard unit.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: bus size.
- `data_wstrb` out 4: bus strobes.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: address phase accepted.
- `data_data_ok` in 1: data phase done.
- `data_rdata` in 32: bus read data.
- `adelM` / `adesM` out 1 each: misaligned load / store (only when `DMEM_ALIGN_CHECK_EN` is defined; otherwise tied 0).

## Operation
- States:
  - IDLE: no transaction.
  - REQ: request issued, address not yet accepted.
  - WAIT: address accepted, awaiting data.
  - HOLD: data returned, waiting for the pipeline to advance.
- `issue = memenM & ~flushM & ~err`. `err` is the alignment error; it is 0 when the check is compiled out.
- `data_req = (IDLE & issue) | REQ`.
- Bus fields are combinational from the M inputs: `data_wr=memwriteM`, `data_size=sizeM`, `data_addr=aluoutM`, `data_wdata=writedataM`.
- `data_wstrb = memwriteM ? sig_write : 4'b0000`.
- Transitions:
  - IDLE → WAIT on `issue & data_addr_ok`.
  - IDLE → REQ on `issue & ~data_addr_ok`.
  - REQ → WAIT on `data_addr_ok`.
  - WAIT → IDLE on `data_data_ok & ~stall_ext`.
  - WAIT → HOLD on `data_data_ok & stall_ext`.
  - HOLD → IDLE on `~stall_ext`.
- Read capture: `rdata_q <= data_rdata` on `WAIT & data_data_ok`.
- `readdataM = WAIT ? data_rdata : rdata_q`.
- `stall_memM = (IDLE & issue) | REQ | (WAIT & ~data_data_ok)`. It is 0 in HOLD.
- `data_data_ok` is ignored outside WAIT. The bus never returns data in the same cycle as `addr_ok`.
- Flush:
  - `flushM` gates a new issue in IDLE only.
  - A request in REQ cannot be withdrawn; it completes normally.
  - The hazard unit discards the result of a flushed instruction; this block still finishes the transaction.
- Stores follow the same FSM. `readdataM` is don't-care for stores; `rdata_q` is still written.

## Timing
- Reset (`rst`=0, asynchronous):
  - State → IDLE, `rdata_q` → 0.
  - `data_req`, `stall_memM`, `adelM`, `adesM`, `readdataM` = 0.
  - Reset mid-transaction abandons it; the bus is reset on the same net.
- Best-case load latency is 2 cycles:
  - Cycle 0: IDLE, request with `addr_ok`=1.
  - Cycle 1: WAIT with `data_ok`=1. `readdataM` is valid and `stall_memM`=0; the M/W register captures at the end of cycle 1.
- Each extra bus wait cycle adds one stall cycle.
- At most one outstanding transaction.
- HOLD blocks re-issue: while `stall_ext`=1 the same M instruction stays put, and no second `data_req` is raised.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - `err` is high for a half access with `aluoutM[0]`=1, or a word access with `aluoutM[1:0]`≠0.
  - With `err` high and `memenM`, `data_req` is suppressed, `adelM` (load) or `adesM` (store) is driven combinationally, and `stall_memM`=0.
- `DMEM_ALIGN_CHECK_EN` not defined: `err`=0, `adelM`=`adesM`=0, and misaligned addresses pass to the bus unchanged.

## Test plan
- Word load from 0x100, bus grants `addr_ok` at once and `data_ok` next cycle with 0xDEADBEEF → `stall_memM` high 1 cycle; `readdataM`=0xDEADBEEF in cycle 1; one `data_req` pulse.
- Byte store 0xAB to 0x203 with `sig_write`=4'b1000, `addr_ok` delayed 3 cycles → `data_req` held 4 cycles with constant fields; `data_wstrb`=4'b1000; stall released on `data_ok`.
- Load completes while `stall_ext`=1 for 4 cycles → FSM sits in HOLD; `readdataM` holds the captured value; no new `data_req`; IDLE once `stall_ext`=0.
- `flushM`=1 with `memenM`=1 in IDLE → no `data_req`, `stall_memM`=0. `flushM` raised in REQ → transaction still completes.
- Reset asserted in WAIT → all outputs 0 immediately; state IDLE after release.
- With `DMEM_ALIGN_CHECK_EN`: word load at 0x102 → `adelM`=1, no `data_req`, `stall_memM`=0. Half store at 0x103 → `adesM`=1.
